// File: rtl/par2ser_pkg.sv
// Shared types and constants for the serial register link (transmitter and deserializer).
package par2ser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_e;

    // Parity polarity: XORed into the word's XOR-reduction; 0 gives even parity.
    localparam logic PARITY_POL = 1'b0;

    function automatic int unsigned cnt_w(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/par2ser_tx_if.sv
// Word handshake plus serial outputs of the transmitter.
interface par2ser_tx_if #(
    parameter int unsigned WIDTH = 10
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;
    logic             sd;
    logic             frame;
    logic             busy;

    modport master (output data, valid, input ready, sd, frame, busy);
    modport slave  (input data, valid, output ready, sd, frame, busy);
endinterface

// File: rtl/par2ser_shift.sv
// Loadable WIDTH-bit shift register; exposes the output-end bit of its next value.
module par2ser_shift #(
    parameter int unsigned WIDTH     = 10,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             nxt_bit_c_o
);

    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_d;

    always_comb begin
        sh_d = sh_q;
        if (load_i) begin
            sh_d = data_i;
        end else if (shift_i) begin
            sh_d = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};
        end
    end

    // Lets the owner register the bit that will be on the line next cycle.
    assign nxt_bit_c_o = MSB_FIRST ? sh_d[WIDTH-1] : sh_d[0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

endmodule

// File: rtl/par2ser_tx.sv
// Parallel-to-serial transmitter: valid/ready word in, framed serial bits out with optional parity.
module par2ser_tx
    import par2ser_pkg::*;
#(
    parameter int unsigned WIDTH     = 10,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          PARITY_EN = 1'b1
) (
    input logic         i_clk,
    input logic         i_rst_n,
    par2ser_tx_if.slave bus
);

    localparam int unsigned CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          par_q, par_d;
    logic          sd_q, sd_d;
    logic          frame_q, frame_d;
    logic          last_c, ready_c, accept_c, load_c, shift_c, nxt_bit_c;

    assign last_c   = (cnt_q == LAST);
    assign ready_c  = (state_q == IDLE) || (state_q == PARITY) ||
                      ((state_q == DATA) && last_c && !PARITY_EN);
    assign accept_c = bus.valid && ready_c;

    par2ser_shift #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .load_i      (load_c),
        .shift_i     (shift_c),
        .data_i      (bus.data),
        .nxt_bit_c_o (nxt_bit_c)
    );

    // Next state, counter, parity and shift control; an accept overrides the frame tail.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        load_c  = 1'b0;
        shift_c = 1'b0;
        unique case (state_q)
            IDLE: ;
            DATA: begin
                shift_c = 1'b1;
                cnt_d   = cnt_q + CW'(1);
                if (last_c) begin
                    state_d = PARITY_EN ? PARITY : IDLE;
                end
            end
            PARITY:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (accept_c) begin
            load_c  = 1'b1;
            shift_c = 1'b0;
            par_d   = (^bus.data) ^ PARITY_POL;
            cnt_d   = '0;
            state_d = DATA;
        end
    end

    // Line outputs are registered from the upcoming state so they align with it.
    always_comb begin
        sd_d    = 1'b0;
        frame_d = 1'b0;
        unique case (state_d)
            DATA: begin
                sd_d    = nxt_bit_c;
                frame_d = 1'b1;
            end
            PARITY: begin
                sd_d    = par_d;
                frame_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            sd_q    <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            sd_q    <= sd_d;
            frame_q <= frame_d;
        end
    end

    assign bus.ready = ready_c;
    assign bus.sd    = sd_q;
    assign bus.frame = frame_q;
    assign bus.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_par2ser_tx.sv
// Drives three transmitter configurations and compares every cycle against a bit-queue model.
module tb_par2ser_tx;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Configurations: 0 = MSB first + parity, 1 = LSB first + parity, 2 = MSB first, no parity.
    localparam bit MSB[3] = '{1'b1, 1'b0, 1'b1};
    localparam bit PAR[3] = '{1'b1, 1'b1, 1'b0};

    logic [9:0] dat[3];
    logic       vld[3];
    logic       rdy_w[3], sd_w[3], frm_w[3], bsy_w[3];

    bit         mq[3][$];
    logic [9:0] src[3][$];
    bit         gappy;
    int         n_vec = 0;
    int         n_err = 0;

    par2ser_tx_if #(.WIDTH(10)) if_a ();
    par2ser_tx_if #(.WIDTH(10)) if_b ();
    par2ser_tx_if #(.WIDTH(10)) if_c ();

    par2ser_tx #(.WIDTH(10), .MSB_FIRST(1'b1), .PARITY_EN(1'b1)) dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(if_a));
    par2ser_tx #(.WIDTH(10), .MSB_FIRST(1'b0), .PARITY_EN(1'b1)) dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(if_b));
    par2ser_tx #(.WIDTH(10), .MSB_FIRST(1'b1), .PARITY_EN(1'b0)) dut_c (.i_clk(clk), .i_rst_n(rst_n), .bus(if_c));

    assign if_a.data = dat[0];
    assign if_a.valid = vld[0];
    assign if_b.data = dat[1];
    assign if_b.valid = vld[1];
    assign if_c.data = dat[2];
    assign if_c.valid = vld[2];
    assign rdy_w[0] = if_a.ready;
    assign sd_w[0]  = if_a.sd;
    assign frm_w[0] = if_a.frame;
    assign bsy_w[0] = if_a.busy;
    assign rdy_w[1] = if_b.ready;
    assign sd_w[1]  = if_b.sd;
    assign frm_w[1] = if_b.frame;
    assign bsy_w[1] = if_b.busy;
    assign rdy_w[2] = if_c.ready;
    assign sd_w[2]  = if_c.sd;
    assign frm_w[2] = if_c.frame;
    assign bsy_w[2] = if_c.busy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame = data bits in send order, then an even-parity bit when enabled.
    task automatic load_frame(input int d, input logic [9:0] w);
        for (int k = 0; k < 10; k++) begin
            mq[d].push_back(MSB[d] ? w[9-k] : w[k]);
        end
        if (PAR[d]) mq[d].push_back(($countones(w) % 2) == 1);
    endtask

    // Queue front is the bit on the line; the block can take a word once at most one bit remains.
    task automatic check_all();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("sd[%0d]", d),    32'(sd_w[d]),  32'((mq[d].size() > 0) ? mq[d][0] : 1'b0));
            chk($sformatf("frame[%0d]", d), 32'(frm_w[d]), 32'(mq[d].size() > 0));
            chk($sformatf("busy[%0d]", d),  32'(bsy_w[d]), 32'(mq[d].size() > 0));
            chk($sformatf("ready[%0d]", d), 32'(rdy_w[d]), 32'(mq[d].size() <= 1));
        end
    endtask

    task automatic drive();
        for (int d = 0; d < 3; d++) begin
            if (src[d].size() > 0 && (!gappy || $urandom_range(0, 3) != 0)) begin
                vld[d] = 1'b1;
                dat[d] = src[d][0];
            end else begin
                vld[d] = 1'b0;
                dat[d] = 10'($urandom);
            end
        end
    endtask

    task automatic step();
        bit acc[3];
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            acc[d] = vld[d] && (mq[d].size() <= 1);
            if (mq[d].size() > 0) void'(mq[d].pop_front());
            if (acc[d]) begin
                load_frame(d, dat[d]);
                void'(src[d].pop_front());
            end
        end
        #1 check_all();
        @(negedge clk);
        drive();
    endtask

    task automatic run_until_idle(input int limit);
        int pending;
        pending = 1;
        for (int i = 0; i < limit && pending != 0; i++) begin
            step();
            pending = 0;
            for (int d = 0; d < 3; d++) pending += src[d].size() + mq[d].size();
        end
        chk("drain", 32'(pending), 32'd0);
    endtask

    task automatic push_all(input logic [9:0] w0, input logic [9:0] w1, input logic [9:0] w2);
        src[0].push_back(w0);
        src[1].push_back(w1);
        src[2].push_back(w2);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            vld[d] = 1'b0;
            dat[d] = '0;
        end
        gappy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Idle handshake: nothing offered for 20 cycles.
        drive();
        repeat (20) step();

        // Single words per configuration; the no-parity unit gets two words back to back.
        push_all(10'h2A5, 10'h001, 10'h155);
        src[2].push_back(10'h2AA);
        drive();
        run_until_idle(60);

        // Back-to-back pair with continuous valid.
        push_all(10'h3FF, 10'h3FF, 10'h3FF);
        push_all(10'h000, 10'h000, 10'h000);
        drive();
        run_until_idle(60);

        // Reset while the first unit is showing bit 4 of 10'h3FF.
        src[0].push_back(10'h3FF);
        drive();
        for (int i = 0; i < 20 && mq[0].size() != 7; i++) step();
        chk("rst_pos", 32'(mq[0].size()), 32'd7);
        #2 rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            mq[d].delete();
            src[d].delete();
            vld[d] = 1'b0;
        end
        #1 check_all();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_all();
        push_all(10'h200, 10'h200, 10'h200);
        drive();
        run_until_idle(40);

        // Random words with random valid gaps.
        gappy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            for (int d = 0; d < 3; d++) src[d].push_back(10'($urandom));
        end
        drive();
        run_until_idle(3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
